layernorm_stream: RTL
=====================

# layernorm_stream

Element-serial, parametrised layer normalisation engine, successor to the fixed 4-element single-cycle `layernorm`. It accepts one signed element per cycle over a valid/ready handshake and buffers a full N-element vector. It computes the mean, variance and integer standard deviation sequentially, then streams out each element normalised to signed fixed point with FRAC_BITS fraction bits. It sits between the token-vector producer and the attention/MLP datapath in the transformer pipeline.

## Interface
- N, 4: elements per vector; power of two, 2..256; LOG2N = log2(N)
- DATA_WIDTH, 8: signed width of input and output elements
- FRAC_BITS, 4: fraction bits of the normalised output
- EPS, 1: integer added to variance; must be ≥1, so the divisor is never 0
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts an element
- in_data  input  DATA_WIDTH  signed input element
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts an element
- out_data  output  DATA_WIDTH  signed normalised element
- out_last  output  1  marks the final element of a vector

## Operation
- FSM states: LOAD, MEAN, VAR, SQRT, DIV, OUT.
- LOAD
  - in_ready=1.
  - Each in_valid&&in_ready stores the element in buf[idx], adds it to sum (width DATA_WIDTH+LOG2N, signed), and increments idx.
  - The Nth handshake goes to MEAN.
- MEAN (1 cycle): mean = sum >>> LOG2N (arithmetic shift, floor). Clear acc and idx, then go to VAR.
- VAR (N cycles)
  - d = buf[idx] - mean (DATA_WIDTH+1 signed).
  - acc += d*d; acc is unsigned, width VAR_W = 2*DATA_WIDTH+2+LOG2N.
  - Leaving VAR latches var = (acc >> LOG2N) + EPS.
- SQRT (SQ_ITERS = ceil(VAR_W/2) cycles): restoring bit-pair integer square root, std = floor(sqrt(var)); std ≥ 1.
- DIV (QW = DATA_WIDTH+1+FRAC_BITS cycles, one quotient bit per cycle) for element idx:
  - q = (|d| << FRAC_BITS) / std, unsigned restoring division.
  - Result = sign(d)·q, i.e. truncation toward zero.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Register the result into out_data, then go to OUT.
- OUT
  - out_valid=1; out_data and out_last stable until out_ready.
  - out_last=1 when idx==N-1.
  - On handshake: if last, go to LOAD with idx=0 and sum=0; otherwise idx++ and go to DIV.
- in_ready=0 in every state except LOAD. A new vector is never accepted until the last output handshake completes.
- in_valid is ignored outside LOAD; out_ready is ignored outside OUT.

## Timing
- Reset (rst_n low, asynchronous):
  - State goes to LOAD; idx, sum, acc, var, std and the quotient are cleared.
  - out_valid=0, out_data=0, out_last=0.
  - in_ready=1 once rst_n is high.
  - Reset mid-vector discards all buffered and partial data; the next accepted element is element 0.
- Input rate: one element per cycle while in_valid=1 in LOAD. Gaps in in_valid stall LOAD with no state loss.
- Latency: out_valid first rises exactly 1+N+SQ_ITERS+QW cycles after the clock edge of the Nth input handshake.
  - For N=4, DATA_WIDTH=8, FRAC_BITS=4: VAR_W=20, SQ_ITERS=10, QW=13, latency=28.
- Throughput: with out_ready held at 1, successive out_valid pulses are QW+1 cycles apart (DIV + OUT).
- Backpressure: out_ready=0 holds OUT indefinitely with outputs stable.
- in_ready rises in the cycle after the final output handshake.

## Test plan
- Default parameters; input 10,20,30,40.
  - Required internals: mean=25, var=126, std=11.
  - Required outputs: -21, -7, 7, 21; out_last only on the 4th output; first out_valid 28 cycles after the 4th input handshake.
- Constant vector 5,5,5,5: var=EPS=1, std=1; outputs 0,0,0,0.
- N=16, FRAC_BITS=6; input fifteen 0s then 64.
  - Required internals: mean=4, var=241, std=15.
  - Required outputs: fifteen -17, then 127 (saturated).
- Backpressure: hold out_ready=0 for 20 cycles in OUT.
  - out_data and out_valid stay stable throughout; in_ready stays 0.
  - Releasing out_ready yields the same sequence as the unstalled run.
- Back-to-back vectors with in_valid held high: the second vector is accepted starting the cycle after the first vector's out_last handshake, and both vectors produce correct results.
- Assert rst_n=0 after 2 input elements (and again during DIV).
  - Outputs go to 0 immediately, in_ready=1 after release.
  - A subsequent full vector 10,20,30,40 produces -21, -7, 7, 21.

Source files
------------

// File: rtl/layernorm_stream_if.sv
// Element-serial stream interface for the layer normalisation engine:
// an input valid/ready channel and an output valid/ready channel with last marker.
interface layernorm_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/layernorm_stream.sv
// Element-serial layer normalisation: buffer N elements, derive mean, variance and
// integer std sequentially, then emit each element as (x-mean)/std in signed fixed point.
//
//   state  | meaning
//   LOAD   | accept elements into the buffer, accumulate sum
//   MEAN   | mean = floor(sum / N)
//   VAR    | accumulate squared deviations, one element per cycle
//   SQRT   | bit-pair restoring square root of variance, one root bit per cycle
//   DIV    | restoring division |d|<<FRAC_BITS / std, one quotient bit per cycle
//   OUT    | present normalised element until the consumer takes it
module layernorm_stream #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4,
  parameter int EPS        = 1
) (
  input logic               clk,
  input logic               rst_n,
  layernorm_stream_if.slave s_if
);
  localparam int DW       = DATA_WIDTH;
  localparam int LOG2N    = $clog2(N);
  localparam int SUM_W    = DW + LOG2N;
  localparam int VAR_W    = 2*DW + 2 + LOG2N;
  localparam int SQ_ITERS = (VAR_W + 1) / 2;
  localparam int SQW      = 2*SQ_ITERS;
  localparam int QW       = DW + 1 + FRAC_BITS;
  localparam int CNT_MAX  = (QW > SQ_ITERS) ? QW : SQ_ITERS;
  localparam int CNT_W    = $clog2(CNT_MAX);
  localparam logic [QW-1:0] POS_LIM = QW'((1 << (DW-1)) - 1);
  localparam logic [QW-1:0] NEG_LIM = QW'(1 << (DW-1));

  typedef enum logic [2:0] {S_LOAD, S_MEAN, S_VAR, S_SQRT, S_DIV, S_OUT} state_t;

  state_t                  state_q, state_d;
  logic [LOG2N-1:0]        idx_q, idx_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic signed [DW-1:0]    mean_q, mean_d;
  logic [VAR_W-1:0]        acc_q, acc_d;
  logic [SQW-1:0]          var_q, var_d;
  logic [SQ_ITERS:0]       sq_rem_q, sq_rem_d;
  logic [SQ_ITERS-1:0]     std_q, std_d;
  logic [SQ_ITERS-1:0]     div_rem_q, div_rem_d;
  logic [QW-2:0]           quo_q, quo_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [DW-1:0]    out_data_q, out_data_d;
  logic signed [DW-1:0]    buf_q [N];
  logic                    buf_we;

  logic signed [DW:0]      d;
  logic [DW:0]             d_abs;
  logic [2*DW+1:0]         d_sq;
  logic [VAR_W-1:0]        acc_sum;
  logic [QW-1:0]           dividend;
  logic [SQ_ITERS+2:0]     sq_trial_rem, sq_trial;
  logic                    sq_ge;
  logic                    div_first;
  logic [SQ_ITERS-1:0]     div_rem_in;
  logic [SQ_ITERS:0]       div_shift;
  logic                    div_ge;
  logic [QW-1:0]           quo_next;
  logic [DW-1:0]           quo_mag;
  logic signed [DW-1:0]    sat;

  // Deviation of the addressed element, shared by VAR and DIV.
  always_comb begin
    d        = (DW+1)'(buf_q[idx_q]) - (DW+1)'(mean_q);
    d_abs    = d[DW] ? $unsigned(-d) : $unsigned(d);
    d_sq     = (2*DW+2)'(d_abs) * (2*DW+2)'(d_abs);
    acc_sum  = acc_q + VAR_W'(d_sq);
    dividend = QW'(d_abs) << FRAC_BITS;

    sq_trial_rem = {sq_rem_q, var_q[SQW-1 -: 2]};
    sq_trial     = (SQ_ITERS+3)'({std_q, 2'b01});
    sq_ge        = sq_trial_rem >= sq_trial;

    div_first  = cnt_q == CNT_W'(QW-1);
    div_rem_in = div_first ? '0 : div_rem_q;
    div_shift  = {div_rem_in, dividend[cnt_q]};
    div_ge     = div_shift >= {1'b0, std_q};
    quo_next   = {quo_q, div_ge};
    quo_mag    = quo_next[DW-1:0];

    if (d[DW]) sat = (quo_next > NEG_LIM) ? $signed(NEG_LIM[DW-1:0]) : $signed(-quo_mag);
    else       sat = (quo_next > POS_LIM) ? $signed(POS_LIM[DW-1:0]) : $signed(quo_mag);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    mean_d     = mean_q;
    acc_d      = acc_q;
    var_d      = var_q;
    sq_rem_d   = sq_rem_q;
    std_d      = std_q;
    div_rem_d  = div_rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    buf_we     = 1'b0;
    case (state_q)
      S_LOAD: if (s_if.in_valid) begin
        buf_we = 1'b1;
        sum_d  = sum_q + SUM_W'(s_if.in_data);
        idx_d  = idx_q + LOG2N'(1);
        if (idx_q == LOG2N'(N-1)) state_d = S_MEAN;
      end
      S_MEAN: begin
        mean_d  = DW'(sum_q >>> LOG2N);
        acc_d   = '0;
        idx_d   = '0;
        state_d = S_VAR;
      end
      S_VAR: begin
        acc_d = acc_sum;
        idx_d = idx_q + LOG2N'(1);
        if (idx_q == LOG2N'(N-1)) begin
          var_d    = SQW'((acc_sum >> LOG2N) + VAR_W'(EPS));
          sq_rem_d = '0;
          std_d    = '0;
          cnt_d    = CNT_W'(SQ_ITERS-1);
          state_d  = S_SQRT;
        end
      end
      S_SQRT: begin
        var_d    = var_q << 2;
        sq_rem_d = (SQ_ITERS+1)'(sq_ge ? sq_trial_rem - sq_trial : sq_trial_rem);
        std_d    = {std_q[SQ_ITERS-2:0], sq_ge};
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(QW-1);
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        div_rem_d = SQ_ITERS'(div_ge ? div_shift - {1'b0, std_q} : div_shift);
        quo_d     = quo_next[QW-2:0];
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          out_data_d = sat;
          state_d    = S_OUT;
        end
      end
      S_OUT: if (s_if.out_ready) begin
        if (idx_q == LOG2N'(N-1)) begin
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_LOAD;
        end else begin
          idx_d   = idx_q + LOG2N'(1);
          cnt_d   = CNT_W'(QW-1);
          state_d = S_DIV;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      idx_q      <= '0;
      sum_q      <= '0;
      mean_q     <= '0;
      acc_q      <= '0;
      var_q      <= '0;
      sq_rem_q   <= '0;
      std_q      <= '0;
      div_rem_q  <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      mean_q     <= mean_d;
      acc_q      <= acc_d;
      var_q      <= var_d;
      sq_rem_q   <= sq_rem_d;
      std_q      <= std_d;
      div_rem_q  <= div_rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
    end
  end

  // Element storage needs no reset: it is always rewritten before being read.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[idx_q] <= s_if.in_data;
  end

  assign s_if.in_ready  = (state_q == S_LOAD);
  assign s_if.out_valid = (state_q == S_OUT);
  assign s_if.out_last  = (state_q == S_OUT) && (idx_q == LOG2N'(N-1));
  assign s_if.out_data  = out_data_q;
endmodule
